// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: reusable BIST harness for combinational gate models.
// A Galois LFSR supplies pseudo-random input patterns and a Galois MISR folds
// the DUT responses into a signature that is compared to a golden value once
// PAT_CNT patterns have been compressed.
module gate_bist_ctrl #(
  parameter int                IN_W      = 12,
  parameter int                OUT_W     = 10,
  parameter int                LFSR_W    = 16,
  parameter int                SIG_W     = 16,
  parameter int                PAT_CNT   = 256,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400),
  parameter logic [SIG_W-1:0]  MISR_TAPS = SIG_W'(16'hB400),
  localparam int               IDX_W     = (PAT_CNT < 1) ? 1 : $clog2(PAT_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] golden,
  input  logic [OUT_W-1:0] resp_in,
  output logic [IN_W-1:0]  pat_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [IDX_W-1:0] pat_idx
);

  // Illegal parameter combinations stop elaboration outright.
  if (IN_W < 1 || IN_W > LFSR_W) begin : g_err_in_w
    $error("gate_bist_ctrl: IN_W must lie in 1..LFSR_W");
  end
  if (OUT_W < 1 || OUT_W > SIG_W) begin : g_err_out_w
    $error("gate_bist_ctrl: OUT_W must lie in 1..SIG_W");
  end
  if (PAT_CNT < 1) begin : g_err_pat_cnt
    $error("gate_bist_ctrl: PAT_CNT must be at least 1");
  end
  if (SEED == '0) begin : g_err_seed
    $error("gate_bist_ctrl: SEED must be nonzero");
  end

  // Pattern count at which the run is complete, in the counter's own width.
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_CNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [LFSR_W-1:0] lfsr, lfsr_nx;
  logic [SIG_W-1:0]  misr, misr_nx;
  logic [IDX_W-1:0]  idx_nx;
  logic              pass_nx;
  logic [SIG_W-1:0]  resp_ext;

  // One Galois shift of the pattern generator.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

  // One Galois shift of the signature register with the response folded in.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [SIG_W-1:0] r);
    misr_step = (s >> 1) ^ (s[0] ? MISR_TAPS : '0) ^ r;
  endfunction

  // Zero-extend the response so narrow DUTs feed only the low MISR bits.
  always_comb begin
    resp_ext              = '0;
    resp_ext[OUT_W-1:0]   = resp_in;
  end

  // Next-state and datapath decisions; abort always beats start or stepping,
  // and an aborted run leaves the pattern, signature and index untouched.
  always_comb begin
    state_nx = state;
    lfsr_nx  = lfsr;
    misr_nx  = misr;
    idx_nx   = pat_idx;
    pass_nx  = pass;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nx = S_RUN;
          lfsr_nx  = SEED;
          misr_nx  = '0;
          idx_nx   = '0;
          pass_nx  = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nx = S_IDLE;
          pass_nx  = 1'b0;
        end else begin
          lfsr_nx = lfsr_step(lfsr);
          misr_nx = misr_step(misr, resp_ext);
          idx_nx  = pat_idx + IDX_W'(1);
          if (idx_nx == IDX_LAST) begin
            state_nx = S_DONE;
            pass_nx  = (misr_nx == golden);
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      lfsr    <= '0;
      misr    <= '0;
      pat_idx <= '0;
      pass    <= 1'b0;
    end else begin
      state   <= state_nx;
      lfsr    <= lfsr_nx;
      misr    <= misr_nx;
      pat_idx <= idx_nx;
      pass    <= pass_nx;
    end
  end

  assign pat_out   = lfsr[IN_W-1:0];
  assign signature = misr;
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

endmodule
